// File: rtl/prob_pkg.sv
// prob_pkg: shared types, default widths and the saturating increment
// used by the result packer and its FIFO.
package prob_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_t;
  localparam int PROB_WORD_W = 8;
  localparam int PROB_CNT_W = 16;
  // w is the live counter width (1..32); the value sticks at all-ones of that width
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w, input logic en);
    return (en && v != (32'hFFFF_FFFF >> (32 - w))) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/prob_skid_fifo2.sv
// prob_skid_fifo2: 2-entry valid/ready FIFO with an EMPTY/ONE/FULL occupancy FSM.
// A push at FULL is accepted only when the head pops in the same cycle; otherwise drop pulses.
module prob_skid_fifo2
  import prob_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         drop
);
  occ_t st;
  logic [W-1:0] head, tail;
  logic pop;
  assign pop = out_valid && pop_ready;
  assign drop = push && st == ST_FULL && !pop_ready;
  assign out_data = head;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= ST_EMPTY;
      head <= '0;
      tail <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      st <= ST_EMPTY;
      head <= '0;
      tail <= '0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        ST_EMPTY: if (push) begin
          head <= push_data;
          st <= ST_ONE;
          out_valid <= 1'b1;
        end
        ST_ONE: if (push && pop) head <= push_data;
          else if (push) begin
            tail <= push_data;
            st <= ST_FULL;
          end else if (pop) begin
            st <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        ST_FULL: if (pop) begin
          head <= tail;
          if (push) tail <= push_data;
          else st <= ST_ONE;
        end
        default: begin
          st <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
endmodule

// File: rtl/prob_result_packer.sv
// prob_result_packer: packs sampled comparator bits LSB-first into words, buffers them in a
// 2-entry FIFO and keeps saturating stats. Define PACK_PARITY_EN to add out_parity.
module prob_result_packer
  import prob_pkg::*;
#(
  parameter int WORD_W = PROB_WORD_W,
  parameter int CNT_W  = PROB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  ones_count,
  output logic [CNT_W-1:0]  total_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow
`ifdef PACK_PARITY_EN
  , output logic            out_parity
`endif
);
  localparam int IW = $clog2(WORD_W);
`ifdef PACK_PARITY_EN
  localparam int DW = WORD_W + 1;
`else
  localparam int DW = WORD_W;
`endif
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] sh, word;
  logic push, drop;
  logic [DW-1:0] push_data, head;
  always_comb begin
    word = sh;
    word[idx] = in_bit;
  end
  assign push = in_valid && idx == IW'(WORD_W - 1);
`ifdef PACK_PARITY_EN
  assign push_data = {^word, word};
  assign out_parity = out_valid & head[WORD_W];
`else
  assign push_data = word;
`endif
  assign out_word = head[WORD_W-1:0];
  prob_skid_fifo2 #(.W(DW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .push(push),
    .push_data(push_data),
    .pop_ready(out_ready),
    .out_valid(out_valid),
    .out_data(head),
    .drop(drop)
  );
  // idx wraps even when the FIFO drops the word, so bit alignment is never lost
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx <= '0;
      sh <= '0;
      ones_count <= '0;
      total_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      idx <= '0;
      sh <= '0;
      ones_count <= '0;
      total_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        sh <= word;
        idx <= push ? '0 : idx + 1'b1;
      end
      total_count <= CNT_W'(sat_inc(32'(total_count), CNT_W, in_valid));
      ones_count <= CNT_W'(sat_inc(32'(ones_count), CNT_W, in_valid && in_bit));
      drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W, drop));
      overflow <= overflow | drop;
    end
endmodule
